// File: rtl/sysfiltr_pkg.sv
// -----------------------------------------------------------------------------
// sysfiltr_pkg
// Shared definitions for the SysFiltr RAM reader: default bus widths, the
// reader FSM state encoding and a constant-evaluable ceil(log2) helper used to
// size FIFO pointers and occupancy counters.
// -----------------------------------------------------------------------------
package sysfiltr_pkg;

  localparam int SF_ADDR_W = 15;
  localparam int SF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sysfiltr_rd_fifo.sv
// -----------------------------------------------------------------------------
// sysfiltr_rd_fifo
// Synchronous show-ahead FIFO. The head entry is presented on rd_data_o while
// the FIFO is non-empty; rd_en_i pops it. A write and a pop in the same cycle
// leave the occupancy unchanged. The writer is expected to never push into a
// full FIFO (the reader's credit scheme guarantees this); an assertion flags it.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pointers/count only)
//   wr_en_i    in   push wr_data_i
//   wr_data_i  in   WIDTH  data to push
//   rd_en_i    in   pop head entry (ignored when empty)
//   rd_data_o  out  WIDTH  head entry, zero when empty
//   empty_o    out  FIFO holds no entries
//   count_o    out  current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sysfiltr_rd_fifo
  import sysfiltr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int               PTR_W    = clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_rd;

  assign do_rd     = rd_en_i & (count_q != '0);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  // Drive zero rather than stale storage when nothing is valid.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en_i, do_rd})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en_i && !do_rd && (count_q == FULL_CNT)));

endmodule

// File: rtl/sysfiltr_ram_reader.sv
// -----------------------------------------------------------------------------
// sysfiltr_ram_reader
// Avalon-MM read master for the SysFiltr on-chip RAM (fixed read latency, no
// waitrequest/readdatavalid). Reads `length` words from `base_addr` upward
// (address wraps modulo 2^ADDR_W) and emits them as one Avalon-ST packet.
// Reads are only issued while (reads in flight + FIFO occupancy) < FIFO_DEPTH,
// so every returning word has a guaranteed FIFO slot and nothing is dropped
// under backpressure.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, base_addr, length     job request (sampled only when idle)
//   busy, done                   job status / one-cycle completion pulse
//   avm_address, avm_chipselect  RAM read request
//   avm_write, avm_byteenable,
//   avm_clken                    tied-off RAM controls
//   avm_readdata                 RAM read data, RD_LATENCY cycles after issue
//   src_data/valid/ready/sop/eop Avalon-ST packet output
// -----------------------------------------------------------------------------
module sysfiltr_ram_reader
  import sysfiltr_pkg::*;
#(
  parameter int ADDR_W     = SF_ADDR_W,
  parameter int DATA_W     = SF_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
  localparam int CR_W   = CNT_W + 1;
  localparam int WORD_W = DATA_W + 2;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issued_q, issued_d;
  logic [LEN_W-1:0]      ret_q, ret_d;       // words written into the FIFO
  logic                  done_zero_q, done_zero_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;          // issue flags, one per latency stage

  logic                  issue;
  logic                  ret_vld;
  logic                  drain_done;
  logic                  pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CR_W-1:0]       inflight;
  logic [CR_W-1:0]       credit_used;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CR_W'(rd_pipe_q[i]);
    end
  end

  assign credit_used = inflight + CR_W'(fifo_count);
  assign ret_vld     = rd_pipe_q[RD_LATENCY-1];

  // Framing is attached on the way into the FIFO; reads return in issue order,
  // so the return index equals the emit index.
  assign wr_word = {(ret_q == '0), (ret_q == (len_q - LEN_W'(1))), avm_readdata};

  assign src_valid = ~fifo_empty;
  assign pop       = src_valid & src_ready;
  assign src_data  = rd_word[DATA_W-1:0];
  assign src_eop   = rd_word[DATA_W];
  assign src_sop   = rd_word[DATA_W+1];

  assign avm_chipselect = issue;
  assign avm_address    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;

  assign busy = (state_q != IDLE);
  assign done = done_zero_q | drain_done;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    ret_d       = ret_q;
    done_zero_d = 1'b0;
    issue       = 1'b0;
    drain_done  = 1'b0;

    if (ret_vld) ret_d = ret_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d  = RUN;
            base_d   = base_addr;
            len_d    = length;
            issued_d = '0;
            ret_d    = '0;
          end else begin
            done_zero_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (credit_used < CR_W'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          issued_d = issued_q + LEN_W'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      ret_q       <= '0;
      done_zero_q <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      ret_q       <= ret_d;
      done_zero_q <= done_zero_d;
      rd_pipe_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  sysfiltr_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en_i   (ret_vld),
    .wr_data_i (wr_word),
    .rd_en_i   (pop),
    .rd_data_o (rd_word),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_sysfiltr_ram_reader.sv
`timescale 1ns/1ps
module tb_sysfiltr_ram_reader;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     length = '0;
  logic            busy, done;
  logic [AW-1:0]   avm_address;
  logic            avm_chipselect, avm_write, avm_clken;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0]   avm_readdata = '0;
  logic [DW-1:0]   src_data;
  logic            src_valid, src_sop, src_eop;
  logic            src_ready = 1'b0;

  logic [DW-1:0]   mem [1<<AW];

  sysfiltr_ram_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_sop        (src_sop),
    .src_eop        (src_eop)
  );

  always #5 clk = ~clk;

  // RAM model: read latency of one cycle.
  always @(posedge clk) begin
    if (avm_chipselect) avm_readdata <= mem[avm_address];
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            ready_pct;
    int            restart_at;       // cycle to pulse a spurious start, 0 = none
    int            exp_first_valid;  // -2 skip, -1 never valid, else cycle
    int            exp_done_cyc;     // -1 skip, else cycle
    logic [DW-1:0] exp_first_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // scoreboard and monitor state
  logic [DW+1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            job_cyc, cs_cnt, pop_cnt, done_cnt, done_cyc, first_valid_cyc;
  int            max_out, stall_err, addr_err;
  logic [AW-1:0] exp_base;
  logic [DW-1:0] first_data;
  bit            first_seen, prev_stall;
  logic [DW+1:0] prev_word;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    int            outst;
    logic [AW-1:0] ea;
    logic [DW+1:0] got, e;
    if (mon_en) begin
      got = {src_sop, src_eop, src_data};
      if (avm_chipselect) begin
        ea = AW'(int'(exp_base) + cs_cnt);
        if (avm_address !== ea) addr_err++;
      end
      outst = cs_cnt - pop_cnt + (avm_chipselect ? 1 : 0);
      if (outst > max_out) max_out = outst;
      if (prev_stall && (src_valid !== 1'b1 || got !== prev_word)) stall_err++;
      if (src_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = job_cyc;
      if (src_valid === 1'b1 && src_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0h, required no word", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL word%0d: got %0h, required %0h", pop_cnt, got, e);
          end
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_data = src_data;
        end
        pop_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = job_cyc;
      end
      if (avm_chipselect) cs_cnt++;
      prev_stall = (src_valid === 1'b1) && !src_ready;
      prev_word  = got;
      job_cyc++;
    end
  end

  function automatic logic rdy(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cs"}, 64'(avm_chipselect), 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_write"}, 64'(avm_write), 64'd0);
    chk({tag, "_be"}, 64'(avm_byteenable), 64'hF);
    chk({tag, "_clken"}, 64'(avm_clken), 64'd1);
    chk({tag, "_valid"}, 64'(src_valid), 64'd0);
    chk({tag, "_data"}, 64'(src_data), 64'd0);
    chk({tag, "_sop"}, 64'(src_sop), 64'd0);
    chk({tag, "_eop"}, 64'(src_eop), 64'd0);
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int budget;
    int k;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      logic [AW-1:0] a;
      a = v.base + AW'(i);
      exp_q.push_back({(i == 0), (i == int'(v.len) - 1), mem[a]});
    end
    cs_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    max_out = 0; stall_err = 0; addr_err = 0; first_seen = 1'b0; prev_stall = 1'b0;
    exp_base = v.base;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; length = v.len;
    src_ready = rdy(v.ready_pct);
    job_cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    src_ready = rdy(v.ready_pct);
    chk({tag, "_busy_c1"}, 64'(busy), 64'(v.len != 0));
    budget = int'(v.len) * 20 + 40;
    k = 1;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (k == v.restart_at) begin
        start = 1'b1; base_addr = 15'h5555; length = 16'd3;
      end else begin
        start = 1'b0;
      end
      src_ready = rdy(v.ready_pct);
    end
    start = 1'b0;
    src_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_cs_cnt"}, 64'(cs_cnt), 64'(v.len));
    chk({tag, "_pop_cnt"}, 64'(pop_cnt), 64'(v.len));
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_credit"}, 64'(max_out <= DEPTH), 64'd1);
    chk({tag, "_stall"}, 64'(stall_err), 64'd0);
    chk({tag, "_addr"}, 64'(addr_err), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    if (v.exp_first_valid != -2)
      chk({tag, "_first_valid"}, 64'(first_valid_cyc), 64'(v.exp_first_valid));
    if (v.exp_done_cyc != -1)
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(v.exp_done_cyc));
    if (v.len != 0)
      chk({tag, "_first_data"}, 64'(first_data), 64'(v.exp_first_data));
    mon_en = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t post;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);

    vecs[0] = '{15'h0010, 16'd8,      100, 0, 3,  -1, 32'h30};
    vecs[1] = '{15'h7FFE, 16'd4,      100, 0, 3,  -1, 32'h17FFA};
    vecs[2] = '{15'h0100, 16'd16,      30, 0, 3,  -1, 32'h300};
    vecs[3] = '{15'h0040, 16'd0,      100, 0, -1,  1, 32'h0};
    vecs[4] = '{15'h0123, 16'd1,      100, 0, 3,  -1, 32'h369};
    vecs[5] = '{15'h0200, 16'd12,      50, 3, 3,  -1, 32'h600};
    vecs[6] = '{15'h0000, 16'h8000,   100, 0, 3,  -1, 32'h0};
    post    = '{15'h0000, 16'd4,      100, 0, 3,  -1, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 7; t++) begin
      run_job($sformatf("job%0d", t), vecs[t]);
    end

    // Reset in the middle of a stalled transfer.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 15'h0300; length = 16'd16; src_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_valid", 64'(src_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_idle("rst_mid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    src_ready = 1'b1;
    repeat (2) @(posedge clk);

    run_job("post_rst", post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
